// File: rtl/soc_clk_div_multi.sv
`default_nettype none
// ============================================================================
// Module   : soc_clk_div_multi
// Brief    : N-channel runtime-programmable clock divider / tick generator
//            with glitch-free divisor updates applied at period boundaries.
// Revision : 1.0 - initial release
// ============================================================================
module soc_clk_div_multi #(
    parameter int NumChannels = 2,
    parameter int CntWidth    = 16,
    parameter int DefaultDiv  = 50
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [NumChannels-1:0]          en_i,
    input  logic [NumChannels*CntWidth-1:0] div_i,
    input  logic [NumChannels-1:0]          div_valid_i,
    output logic [NumChannels-1:0]          div_ready_o,
    output logic [NumChannels*CntWidth-1:0] cur_div_o,
    output logic [NumChannels-1:0]          clk_o,
    output logic [NumChannels-1:0]          tick_o
);

    localparam logic [CntWidth-1:0] c_default_div = CntWidth'(DefaultDiv);
    localparam logic [CntWidth-1:0] c_one         = CntWidth'(1);

    for (genvar c = 0; c < NumChannels; c++) begin : g_ch
        logic                r_en;
        logic [CntWidth-1:0] r_cnt;
        logic [CntWidth-1:0] r_cur;
        logic [CntWidth-1:0] r_pend;
        logic                r_pend_v;
        logic                r_clk;

        logic [CntWidth-1:0] w_div_in;
        logic [CntWidth-1:0] w_cur_nxt;
        logic [CntWidth-1:0] w_cnt_nxt;
        logic [CntWidth-1:0] w_half_nxt;
        logic                w_run;
        logic                w_last;
        logic                w_fire;
        logic                w_apply;
        logic                w_run_nxt;
        logic                w_clk_nxt;

        assign w_div_in = div_i[c*CntWidth +: CntWidth];

        always_comb begin
            w_run     = r_en && (r_cur != '0);
            // With D==1 the counter sits at 0 == D-1, so every edge is a period end.
            w_last    = (r_cnt == (r_cur - c_one));
            w_fire    = div_valid_i[c] && !r_pend_v;
            // Pending divisor lands at a period end, or as soon as the channel stops.
            w_apply   = r_pend_v && (!r_en || !en_i[c] || w_last);

            w_cur_nxt = r_cur;
            if (w_apply) begin
                w_cur_nxt = r_pend;
            end else if (w_fire && !w_run) begin
                w_cur_nxt = w_div_in;
            end

            w_run_nxt = en_i[c] && (w_cur_nxt != '0);
            w_cnt_nxt = (!w_run_nxt || !w_run || w_last) ? '0 : (r_cnt + c_one);

            // High phase is ceil(D/2) cycles; output is precomputed so clk_o is a flop.
            w_half_nxt = (w_cur_nxt >> 1) + {{(CntWidth-1){1'b0}}, w_cur_nxt[0]};
            w_clk_nxt  = w_run_nxt && (w_cnt_nxt < w_half_nxt);
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_en     <= 1'b0;
                r_cnt    <= '0;
                r_cur    <= c_default_div;
                r_pend   <= '0;
                r_pend_v <= 1'b0;
                r_clk    <= 1'b0;
            end else begin
                r_en  <= en_i[c];
                r_cnt <= w_cnt_nxt;
                r_cur <= w_cur_nxt;
                r_clk <= w_clk_nxt;
                if (w_fire && w_run) begin
                    r_pend   <= w_div_in;
                    r_pend_v <= 1'b1;
                end else if (w_apply) begin
                    r_pend_v <= 1'b0;
                end
            end
        end

        assign div_ready_o[c]                     = !r_pend_v;
        assign cur_div_o[c*CntWidth +: CntWidth]  = r_cur;
        assign clk_o[c]                           = r_clk;
        assign tick_o[c]                          = w_run && (r_cnt == '0);
    end

endmodule
`default_nettype wire

// File: tb/tb_soc_clk_div_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_soc_clk_div_multi
// Brief    : Scoreboard bench for soc_clk_div_multi with directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_soc_clk_div_multi;

    logic        clk_i;
    logic        rst_ni;
    logic [1:0]  en_i;
    logic [31:0] div_i;
    logic [1:0]  div_valid_i;
    logic [1:0]  div_ready_o;
    logic [31:0] cur_div_o;
    logic [1:0]  clk_o;
    logic [1:0]  tick_o;

    soc_clk_div_multi #(
        .NumChannels (2),
        .CntWidth    (16),
        .DefaultDiv  (50)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .en_i        (en_i),
        .div_i       (div_i),
        .div_valid_i (div_valid_i),
        .div_ready_o (div_ready_o),
        .cur_div_o   (cur_div_o),
        .clk_o       (clk_o),
        .tick_o      (tick_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        int    at;
        int    ch;
        bit    clk;
        bit    tick;
        bit    rdy;
        int    cur;
        string nm;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    task automatic ex(input int at, input int ch, input bit c, input bit t,
                      input bit r, input int cur, input string nm);
        exp_t e;
        e.at = at; e.ch = ch; e.clk = c; e.tick = t; e.rdy = r; e.cur = cur; e.nm = nm;
        sb.push_back(e);
    endtask

    // Expected waveform of undisturbed periods: high ceil(D/2), tick on first cycle.
    task automatic per(input int ch, input int start, input int d, input int nper,
                       input string nm);
        for (int p = 0; p < nper; p++)
            for (int k = 0; k < d; k++)
                ex(start + p*d + k, ch, k < (d+1)/2, k == 0, 1'b1, d, nm);
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic setdiv(input int ch, input int val);
        div_i[ch*16 +: 16] = 16'(val);
    endtask

    // Monitor: compare every expectation that falls due in the current cycle.
    always @(negedge clk_i) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].at <= cyc) begin
                n_vec++;
                if (sb[i].at < cyc) begin
                    n_fail++;
                    $display("FAIL %s ch%0d: expectation for cyc%0d not checked (now %0d)",
                             sb[i].nm, sb[i].ch, sb[i].at, cyc);
                end else if (clk_o[sb[i].ch] !== sb[i].clk ||
                             tick_o[sb[i].ch] !== sb[i].tick ||
                             div_ready_o[sb[i].ch] !== sb[i].rdy ||
                             cur_div_o[sb[i].ch*16 +: 16] !== 16'(sb[i].cur)) begin
                    n_fail++;
                    $display("FAIL %s ch%0d cyc%0d: clk/tick/rdy/cur got %b/%b/%b/%0d want %b/%b/%b/%0d",
                             sb[i].nm, sb[i].ch, cyc,
                             clk_o[sb[i].ch], tick_o[sb[i].ch], div_ready_o[sb[i].ch],
                             cur_div_o[sb[i].ch*16 +: 16],
                             sb[i].clk, sb[i].tick, sb[i].rdy, sb[i].cur);
                end
                sb.delete(i);
            end
        end
    end

    initial begin
        int t0, c, c2, e, p, f, g, q0, r, h, pp;
        rst_ni      = 1'b1;
        en_i        = 2'b00;
        div_i       = '0;
        div_valid_i = 2'b00;
        #2 rst_ni   = 1'b0;
        cycles(3);

        // Reset state and D=50 from reset release
        ex(cyc, 0, 0, 0, 1, 50, "reset_ch0");
        ex(cyc, 1, 0, 0, 1, 50, "reset_ch1");
        cycles(1);
        t0 = cyc;
        rst_ni = 1'b1;
        en_i   = 2'b01;
        ex(t0, 0, 0, 0, 1, 50, "pre_enable");
        per(0, t0 + 1, 50, 2, "div50");
        ex(t0 + 101, 0, 1, 1, 1, 50, "div50_tick3");
        ex(t0 + 10, 1, 0, 0, 1, 50, "ch1_idle");
        cycles(101);

        // Odd divisor 5, then D=1
        c  = cyc;
        c2 = c + 2;
        en_i[0] = 1'b0;
        ex(c + 1, 0, 0, 0, 1, 50, "disabled");
        ex(c2, 0, 0, 0, 1, 5, "direct_write5");
        per(0, c2 + 1, 5, 2, "div5");
        ex(c2 + 11, 0, 1, 1, 1, 5, "div5_p3");
        ex(c2 + 12, 0, 1, 0, 1, 5, "div5_p3");
        ex(c2 + 13, 0, 1, 0, 1, 5, "div5_p3");
        ex(c2 + 14, 0, 0, 0, 0, 5, "div5_pend");
        ex(c2 + 15, 0, 0, 0, 0, 5, "div5_pend");
        for (int k = 16; k <= 20; k++) ex(c2 + k, 0, 1, 1, 1, 1, "div1");
        cycles(1);
        setdiv(0, 5); div_valid_i[0] = 1'b1;
        cycles(1);
        div_valid_i[0] = 1'b0; en_i[0] = 1'b1;
        cycles(13);
        setdiv(0, 1); div_valid_i[0] = 1'b1;
        cycles(1);
        div_valid_i[0] = 1'b0;
        cycles(7);

        // Mid-period update 10 -> 4
        e = cyc;
        p = e + 2;
        ex(e, 0, 1, 1, 1, 1, "div1_req");
        ex(e + 1, 0, 1, 1, 0, 1, "div1_pend");
        for (int k = 0; k < 10; k++)
            ex(p + k, 0, k < 5, k == 0, k < 4, 10, "div10_upd");
        per(0, p + 10, 4, 2, "div4");
        setdiv(0, 10); div_valid_i[0] = 1'b1;
        cycles(1);
        div_valid_i[0] = 1'b0;
        cycles(4);
        setdiv(0, 4); div_valid_i[0] = 1'b1;
        cycles(1);
        div_valid_i[0] = 1'b0;
        cycles(14);

        // D=0 stop, then D=8 with disable / re-enable
        f = cyc;
        en_i[0] = 1'b0;
        ex(f, 0, 1, 1, 1, 4, "div4_end");
        ex(f + 1, 0, 0, 0, 1, 4, "dis_div4");
        for (int k = 2; k <= 12; k++) ex(f + k, 0, 0, 0, 1, 0, "div0_stop");
        per(0, f + 13, 8, 1, "div8");
        ex(f + 21, 0, 1, 1, 1, 8, "div8_p2");
        ex(f + 23, 0, 1, 0, 1, 8, "div8_p2");
        ex(f + 24, 0, 0, 0, 1, 8, "div8_off");
        ex(f + 25, 0, 0, 0, 1, 8, "div8_off");
        ex(f + 26, 0, 1, 1, 1, 8, "reenable");
        ex(f + 27, 0, 1, 0, 1, 8, "reenable");
        cycles(1);
        setdiv(0, 0); div_valid_i[0] = 1'b1;
        cycles(1);
        div_valid_i[0] = 1'b0; en_i[0] = 1'b1;
        cycles(10);
        setdiv(0, 8); div_valid_i[0] = 1'b1;
        cycles(1);
        div_valid_i[0] = 1'b0;
        cycles(10);
        en_i[0] = 1'b0;
        cycles(2);
        en_i[0] = 1'b1;
        cycles(3);

        // Reset with update pending, then pending applied as enable falls
        g  = cyc;
        q0 = g + 6;
        r  = q0 + 14;
        ex(g, 0, 1, 0, 1, 8, "div8_req20");
        ex(g + 1, 0, 1, 0, 0, 8, "div8_pend20");
        ex(g + 5, 0, 0, 0, 0, 8, "div8_last");
        ex(q0, 0, 1, 1, 1, 20, "div20_start");
        ex(q0 + 11, 0, 0, 0, 0, 20, "div20_pend7");
        ex(q0 + 12, 0, 0, 0, 1, 50, "async_reset");
        ex(q0 + 12, 1, 0, 0, 1, 50, "async_reset");
        ex(r, 0, 0, 0, 1, 50, "post_reset");
        ex(r + 1, 0, 1, 1, 1, 50, "post_reset");
        ex(r + 2, 0, 1, 0, 1, 50, "post_reset");
        ex(r + 50, 0, 0, 0, 1, 50, "pend_discard");
        ex(r + 51, 0, 1, 1, 1, 50, "pend_discard");
        ex(r + 52, 0, 1, 0, 0, 50, "pend6");
        ex(r + 53, 0, 1, 0, 0, 50, "pend6");
        ex(r + 54, 0, 0, 0, 1, 6, "dis_apply6");
        ex(r + 55, 0, 1, 1, 1, 6, "div6");
        ex(r + 56, 0, 1, 0, 1, 6, "div6");
        ex(r + 57, 0, 1, 0, 1, 6, "div6");
        ex(r + 58, 0, 0, 0, 1, 6, "div6");
        setdiv(0, 20); div_valid_i[0] = 1'b1;
        cycles(1);
        div_valid_i[0] = 1'b0;
        cycles(15);
        setdiv(0, 7); div_valid_i[0] = 1'b1;
        cycles(1);
        div_valid_i[0] = 1'b0;
        cycles(1);
        #1 rst_ni = 1'b0;
        en_i = 2'b00;
        cycles(2);
        rst_ni = 1'b1;
        en_i[0] = 1'b1;
        cycles(51);
        setdiv(0, 6); div_valid_i[0] = 1'b1;
        cycles(1);
        div_valid_i[0] = 1'b0;
        cycles(1);
        en_i[0] = 1'b0;
        cycles(1);
        en_i[0] = 1'b1;
        cycles(5);

        // Channel independence and maximum divisor
        h  = cyc;
        pp = h + 3;
        en_i = 2'b00;
        ex(h + 1, 0, 0, 0, 1, 6, "ch0_off");
        ex(h + 2, 0, 0, 0, 1, 3, "ch0_set3");
        ex(h + 2, 1, 0, 0, 1, 65535, "ch1_setmax");
        per(0, pp, 3, 5, "div3");
        ex(pp + 65535, 0, 1, 1, 1, 3, "div3_late");
        ex(pp, 1, 1, 1, 1, 65535, "max_tick1");
        ex(pp + 1, 1, 1, 0, 1, 65535, "max_run");
        ex(pp + 7, 1, 1, 0, 1, 65535, "max_ready");
        ex(pp + 8, 1, 1, 0, 0, 65535, "max_pend");
        ex(pp + 32767, 1, 1, 0, 0, 65535, "max_high_end");
        ex(pp + 32768, 1, 0, 0, 0, 65535, "max_low_start");
        ex(pp + 65534, 1, 0, 0, 0, 65535, "max_last");
        ex(pp + 65535, 1, 1, 1, 1, 100, "max_tick2");
        ex(pp + 65536, 1, 1, 0, 1, 100, "div100");
        ex(pp + 65585, 1, 0, 0, 1, 100, "div100_low");
        ex(pp + 65635, 1, 1, 1, 1, 100, "div100_tick");
        cycles(1);
        setdiv(0, 3); setdiv(1, 65535); div_valid_i = 2'b11;
        cycles(1);
        div_valid_i = 2'b00; en_i = 2'b11;
        cycles(8);
        setdiv(0, 7); setdiv(1, 100); div_valid_i = 2'b10;
        cycles(1);
        div_valid_i = 2'b00;
        cycles(65628);

        @(negedge clk_i);
        #1;
        if (sb.size() != 0) begin
            n_fail += sb.size();
            $display("FAIL leftover: %0d expectations never checked, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
